// File: rtl/freq_counter_pkg.sv
// Shared constants and helpers for the multi-channel frequency counter.
// Holds the 7-segment patterns and the saturating adder used by every channel.
package freq_counter_pkg;

    localparam int unsigned SEG_W    = 7;
    localparam int unsigned DISP_MAX = 99;

    localparam logic [SEG_W-1:0] SEG_DIGIT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };
    localparam logic [SEG_W-1:0] SEG_DASH = 7'h40;

    // a + b clamped to max_v
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_v);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max_v}) ? max_v : sum[31:0];
    endfunction

    function automatic logic [SEG_W-1:0] seg_digit(input logic [3:0] d);
        return (d <= 4'd9) ? SEG_DIGIT[d] : SEG_DASH;
    endfunction

endpackage

// File: rtl/freq_counter_mc_chan.sv
// One measurement channel: synchroniser, edge detect, saturating live counter,
// and the per-window latch with its saturation flag.
module freq_chan
    import freq_counter_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_sig,
    input  logic             i_both_edges,
    input  logic             i_close,
    output logic [CNT_W-1:0] o_next_c,
    output logic             o_sat
);

    localparam logic [31:0] MAX_V = 32'((64'(1) << CNT_W) - 64'(1));

    logic             r_sync1;
    logic             r_sync2;
    logic             r_prev;
    logic [CNT_W-1:0] r_live;
    logic             r_live_sat;
    logic [CNT_W-1:0] r_latched;
    logic             r_sat;

    logic             w_edge;
    logic             w_at_max;
    logic [CNT_W-1:0] w_sum;

    assign w_edge   = (r_sync2 & ~r_prev) | (i_both_edges & ~r_sync2 & r_prev);
    assign w_at_max = (32'(r_live) == MAX_V);
    assign w_sum    = CNT_W'(sat_add(32'(r_live), 32'(w_edge), MAX_V));

    // An edge seen in the close cycle is folded into the closing window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_prev     <= 1'b0;
            r_live     <= '0;
            r_live_sat <= 1'b0;
            r_latched  <= '0;
            r_sat      <= 1'b0;
        end else begin
            r_sync1 <= i_sig;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (i_close) begin
                r_latched  <= w_sum;
                r_sat      <= r_live_sat | (w_at_max & w_edge);
                r_live     <= '0;
                r_live_sat <= 1'b0;
            end else if (w_edge) begin
                if (w_at_max) begin
                    r_live_sat <= 1'b1;
                end else begin
                    r_live <= r_live + CNT_W'(1);
                end
            end
        end
    end

    // Value the latch holds from the next cycle on; lets the parent register it in step.
    assign o_next_c = i_close ? w_sum : r_latched;
    assign o_sat    = r_sat;

endmodule

// File: rtl/freq_counter_mc.sv
// Multi-channel gated edge counter with a two-digit multiplexed 7-segment
// readout of the selected channel.
module freq_counter_mc
    import freq_counter_pkg::*;
#(
    parameter int unsigned N_CH           = 4,
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned GATE_CYCLES    = 1000000,
    parameter int unsigned REFRESH_CYCLES = 1000,
    localparam int unsigned SEL_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  sig_in,
    input  logic             both_edges,
    input  logic [SEL_W-1:0] ch_sel,
    output logic [6:0]       segments,
    output logic             digit,
    output logic [CNT_W-1:0] count_out,
    output logic [N_CH-1:0]  sat,
    output logic             update
);

    localparam int unsigned GATE_W = $clog2(GATE_CYCLES);
    localparam int unsigned REF_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    logic [GATE_W-1:0]           r_gate;
    logic [REF_W-1:0]            r_ref;
    logic                        r_digit;
    logic [SEG_W-1:0]            r_seg;
    logic [CNT_W-1:0]            r_count;
    logic                        r_update;

    logic                        w_close;
    logic                        w_ref_wrap;
    logic                        w_digit_next;
    logic [N_CH-1:0][CNT_W-1:0]  w_next;
    logic [N_CH-1:0]             w_sat;
    logic [CNT_W-1:0]            w_sel_val;
    logic [31:0]                 w_v32;
    logic [3:0]                  w_tens;
    logic [3:0]                  w_units;
    logic [SEG_W-1:0]            w_seg_next;

    assign w_close      = (r_gate == GATE_W'(GATE_CYCLES - 1));
    assign w_ref_wrap   = (r_ref == REF_W'(REFRESH_CYCLES - 1));
    assign w_digit_next = r_digit ^ w_ref_wrap;

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        freq_chan #(
            .CNT_W(CNT_W)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_sig       (sig_in[g]),
            .i_both_edges(both_edges),
            .i_close     (w_close),
            .o_next_c    (w_next[g]),
            .o_sat       (w_sat[g])
        );
    end

    always_comb begin
        w_sel_val = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_sel == SEL_W'(i)) begin
                w_sel_val = w_next[i];
            end
        end
    end

    // Binary to two decimal digits; values past 99 show dashes on both digits.
    always_comb begin
        w_v32   = 32'(w_sel_val);
        w_tens  = 4'(w_v32 / 32'd10);
        w_units = 4'(w_v32 % 32'd10);
        if (w_v32 > 32'(DISP_MAX)) begin
            w_seg_next = SEG_DASH;
        end else if (w_digit_next) begin
            w_seg_next = seg_digit(w_tens);
        end else begin
            w_seg_next = seg_digit(w_units);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gate   <= '0;
            r_ref    <= '0;
            r_digit  <= 1'b0;
            r_seg    <= '0;
            r_count  <= '0;
            r_update <= 1'b0;
        end else begin
            r_gate   <= w_close ? '0 : r_gate + GATE_W'(1);
            r_ref    <= w_ref_wrap ? '0 : r_ref + REF_W'(1);
            r_digit  <= w_digit_next;
            r_seg    <= w_seg_next;
            r_count  <= w_sel_val;
            r_update <= w_close;
        end
    end

    assign segments  = r_seg;
    assign digit     = r_digit;
    assign count_out = r_count;
    assign sat       = w_sat;
    assign update    = r_update;

endmodule

// File: tb/tb_freq_counter_mc.sv
// Self-checking bench for freq_counter_mc: directed table vectors, corner
// sequences and randomised traffic checked every cycle against a window model.
module tb_freq_counter_mc;

    localparam int G    = 100;
    localparam int R    = 4;
    localparam int HMAX = 1024;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] sig_in;
    logic       both_edges;
    logic [0:0] ch_sel;
    logic [6:0] segments;
    logic       digit;
    logic [7:0] count_out;
    logic [1:0] sat;
    logic       update;

    logic [1:0] sig4;
    logic       both4;
    logic [0:0] sel4;
    logic [6:0] seg4;
    logic       dig4;
    logic [3:0] cnt4;
    logic [1:0] sat4;
    logic       upd4;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [1:0] s_hist   [HMAX];
    logic       be_hist  [HMAX];
    logic       sel_hist [HMAX];

    always #5 clk = ~clk;

    freq_counter_mc #(.N_CH(2), .CNT_W(8), .GATE_CYCLES(G), .REFRESH_CYCLES(R)) dut (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .both_edges(both_edges),
        .ch_sel(ch_sel), .segments(segments), .digit(digit),
        .count_out(count_out), .sat(sat), .update(update)
    );

    freq_counter_mc #(.N_CH(2), .CNT_W(4), .GATE_CYCLES(G), .REFRESH_CYCLES(R)) dut4 (
        .clk(clk), .rst_n(rst_n), .sig_in(sig4), .both_edges(both4),
        .ch_sel(sel4), .segments(seg4), .digit(dig4),
        .count_out(cnt4), .sat(sat4), .update(upd4)
    );

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    // Input value held during cycle k becomes an edge decision in cycle k+2,
    // which belongs to window (k+2)/G.
    function automatic int win_count(input int ch, input int w);
        int   n;
        int   lo;
        int   hi;
        logic cur;
        logic prev;
        n  = 0;
        lo = w * G - 2;
        hi = (w + 1) * G - 3;
        if (lo < 0) lo = 0;
        for (int k = lo; k <= hi; k++) begin
            cur  = s_hist[k][ch];
            prev = (k > 0) ? s_hist[k-1][ch] : 1'b0;
            if ((cur && !prev) || (be_hist[k+2] && !cur && prev)) n++;
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_check();
        int c;
        int w;
        int n;
        int v;
        int dg;
        logic [1:0] es;
        logic [6:0] eseg;
        c  = cyc;
        w  = c / G - 1;
        v  = 0;
        es = 2'b00;
        if (c >= G) begin
            n = win_count(int'(sel_hist[c-1]), w);
            v = (n > 255) ? 255 : n;
            for (int i = 0; i < 2; i++) es[i] = (win_count(i, w) > 255);
        end
        dg   = (c / R) % 2;
        eseg = (v > 99) ? 7'h40 : ((dg == 1) ? seg_of(v / 10) : seg_of(v % 10));
        check("m_update", 32'(update), 32'((c >= G) && (c % G == 0)));
        check("m_count", 32'(count_out), 32'(v));
        check("m_sat", 32'(sat), 32'(es));
        check("m_digit", 32'(digit), 32'(dg));
        check("m_segments", 32'(segments), 32'(eseg));
    endtask

    task automatic tick();
        if (cyc >= HMAX) begin
            $display("FAIL history overflow cycle %0d", cyc);
            $fatal(1);
        end
        s_hist[cyc]   = sig_in;
        be_hist[cyc]  = both_edges;
        sel_hist[cyc] = ch_sel[0];
        @(posedge clk);
        #1;
        cyc++;
        model_check();
    endtask

    task automatic check_reset_outputs();
        check("rst_segments", 32'(segments), 32'h0);
        check("rst_digit", 32'(digit), 32'h0);
        check("rst_count", 32'(count_out), 32'h0);
        check("rst_sat", 32'(sat), 32'h0);
        check("rst_update", 32'(update), 32'h0);
        check("rst_count4", 32'(cnt4), 32'h0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
        sig_in = 2'b00;
        sig4   = 2'b00;
        #2;
        check_reset_outputs();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic run_sq(input int ncyc, input int period, input int ch);
        for (int i = 0; i < ncyc; i++) begin
            sig_in     = 2'b00;
            sig_in[ch] = ((cyc % period) < (period / 2));
            sig4[0]    = ((cyc % 4) < 2);
            tick();
        end
    endtask

    typedef struct {
        int         period;
        int         drive_ch;
        logic       be;
        logic       sel;
        int         exp_cnt;
        logic [6:0] exp_tens;
        logic [6:0] exp_units;
    } vec_t;

    vec_t vt [4];

    initial begin
        rst_n      = 1'b0;
        sig_in     = 2'b00;
        sig4       = 2'b00;
        both_edges = 1'b0;
        ch_sel     = 1'b0;
        both4      = 1'b0;
        sel4       = 1'b0;

        vt[0] = '{10, 0, 1'b0, 1'b0, 10,  7'h06, 7'h3F};
        vt[1] = '{10, 0, 1'b1, 1'b0, 20,  7'h5B, 7'h3F};
        vt[2] = '{2,  1, 1'b1, 1'b1, 100, 7'h40, 7'h40};
        vt[3] = '{10, 0, 1'b1, 1'b1, 0,   7'h3F, 7'h3F};

        for (int t = 0; t < 4; t++) begin
            do_reset();
            both_edges = vt[t].be;
            ch_sel     = vt[t].sel;
            run_sq(1, vt[t].period, vt[t].drive_ch);
            check("post_rst_seg", 32'(segments), 32'h3F);
            run_sq(2 * G - 1, vt[t].period, vt[t].drive_ch);
            check("tv_update", 32'(update), 32'h1);
            check("tv_count", 32'(count_out), 32'(vt[t].exp_cnt));
            check("tv_sat", 32'(sat), 32'h0);
            check("tv_units_digit", 32'(digit), 32'h0);
            check("tv_units_seg", 32'(segments), 32'(vt[t].exp_units));
            if (t == 0) begin
                check("sat4_count", 32'(cnt4), 32'd15);
                check("sat4_flag", 32'(sat4[0]), 32'h1);
            end
            run_sq(R, vt[t].period, vt[t].drive_ch);
            check("tv_tens_digit", 32'(digit), 32'h1);
            check("tv_tens_seg", 32'(segments), 32'(vt[t].exp_tens));
            if (t == 1) begin
                ch_sel = 1'b1;
                run_sq(1, vt[t].period, vt[t].drive_ch);
                check("sel_switch_count", 32'(count_out), 32'h0);
            end
        end

        // Rising edge whose decision lands exactly in the close cycle.
        do_reset();
        both_edges = 1'b0;
        ch_sel     = 1'b0;
        for (int i = 0; i < G; i++) begin
            sig_in = (cyc >= G - 3) ? 2'b01 : 2'b00;
            tick();
        end
        check("close_edge_count", 32'(count_out), 32'd1);
        check("close_edge_update", 32'(update), 32'h1);
        for (int i = 0; i < G; i++) tick();
        check("close_edge_next", 32'(count_out), 32'd0);

        // Reset in the middle of a window with edges already counted.
        do_reset();
        run_sq(150, 10, 0);
        check("pre_rst_count", 32'(count_out), 32'd10);
        do_reset();
        for (int i = 0; i < G; i++) begin
            sig_in = ((cyc < 30) && ((cyc % 10) < 5)) ? 2'b01 : 2'b00;
            tick();
        end
        check("post_rst_update", 32'(update), 32'h1);
        check("post_rst_count", 32'(count_out), 32'd3);

        // Randomised traffic with per-window activity and occasional control changes.
        do_reset();
        for (int w = 0; w < 8; w++) begin
            int act0;
            int act1;
            act0 = $urandom_range(0, 100);
            act1 = $urandom_range(0, 100);
            for (int i = 0; i < G; i++) begin
                if ($urandom_range(0, 99) < act0) sig_in[0] = ~sig_in[0];
                if ($urandom_range(0, 99) < act1) sig_in[1] = ~sig_in[1];
                if ($urandom_range(0, 49) == 0) both_edges = ~both_edges;
                if ($urandom_range(0, 19) == 0) ch_sel = ~ch_sel;
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/freq_counter_mc.md
# freq_counter_mc

Multi-channel successor to the single-input Tiny Tapeout frequency counter. It counts edges on `N_CH` asynchronous input signals over a shared, parametrised gate window, latches per-channel results with saturation, and drives a multiplexed two-digit decimal 7-segment display for one selected channel. It sits directly under the `tt_um_` top wrapper: `ui_in` carries the signals and selects, and `uo_out`/`uio_out` carry the display and status.

## Interface

Parameters:
- `N_CH`, 4: number of input channels (≥1).
- `CNT_W`, 8: width of the per-channel edge counter and latched result.
- `GATE_CYCLES`, 1000000: clk cycles per gate window (≥2).
- `REFRESH_CYCLES`, 1000: clk cycles per display digit phase (≥1).

Ports:
- `clk` in 1: system clock; only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `sig_in` in `N_CH`: asynchronous measured signals.
- `both_edges` in 1: 0 = count rising edges only; 1 = count rising and falling edges.
- `ch_sel` in `max(1,$clog2(N_CH))`: channel shown on `count_out` and on the display.
- `segments` out 7: active-high segments, bit0 = a … bit6 = g.
- `digit` out 1: 0 = units digit is driven, 1 = tens digit is driven.
- `count_out` out `CNT_W`: latched count of the selected channel.
- `sat` out `N_CH`: per-channel flag, set when that channel's last window saturated.
- `update` out 1: one-cycle pulse when the latched results refresh.

## Operation

- Per channel, the input path is a 2-flop synchroniser followed by a previous-value register. The edge term is `rise | (both_edges & fall)`, evaluated on the synchronised signal.
- Live counter: increments on each edge and saturates at 2^CNT_W−1. It sets an internal saturation bit when an edge arrives while the counter is already at max.
- Gate counter: runs 0..GATE_CYCLES−1 and wraps. It is shared by all channels.
- Close cycle (gate == GATE_CYCLES−1), per channel:
  - latched ← saturating (live + edge_this_cycle);
  - `sat[i]` ← saturation of that sum;
  - live ← 0, with its saturation bit cleared.
  - An edge detected in the close cycle belongs to the closing window.
- `update` is registered. It is high during the cycle after the close cycle.
- `both_edges` changes take effect on the next detected edge. The window does not restart.
- Display path:
  - v = latched[ch_sel].
  - If v ≤ 99: tens digit = v/10 and units digit = v%10, both decoded to standard 7-seg patterns. A tens digit of 0 is still shown as '0'.
  - If v > 99: both digits show a dash (7'h40).
- `digit` toggles every REFRESH_CYCLES cycles, driven by its own refresh counter. `segments` shows the digit that `digit` indicates.

## Timing

- Reset values: `segments`=0, `digit`=0, `count_out`=0, `sat`=0, `update`=0. All counters and latches are 0 and the synchronisers are 0.
- First cycle after reset release: `segments`=7'h3F ('0'), because segments are registered from latched=0.
- Input-to-count latency: an edge on `sig_in` is counted 3 clk edges after the change (2 synchroniser stages plus 1 edge-detect stage).
- First close cycle is gate count GATE_CYCLES−1 after reset release. `update` is high in cycle GATE_CYCLES, then every GATE_CYCLES cycles after that.
- `count_out`, `sat` and `segments` reflect new latches in the same cycle `update` is high.
- `ch_sel` change: `count_out` and `segments` follow 1 cycle later.
- `digit` toggles at cycles REFRESH_CYCLES, 2·REFRESH_CYCLES, and so on. `segments` switches in the same cycle `digit` toggles.
- Reset mid-window clears all state immediately. The partial window is discarded and no `update` is produced for it.

## Structure

- Package `freq_counter_pkg`:
  - `SEG_DIGIT[0:9]` segment constants;
  - `SEG_DASH` = 7'h40;
  - a saturating-add function.
- Sub-module `freq_chan`: synchroniser, edge detect, live counter, latch and sat flag. Instantiated `N_CH` times with generate. It receives the close strobe from the parent.
- Parent block holds:
  - the gate counter;
  - the refresh counter;
  - the `ch_sel` mux;
  - the binary-to-two-digit decode;
  - the output registers.

## Test plan

All scenarios use N_CH=2, CNT_W=8, GATE_CYCLES=100, REFRESH_CYCLES=4 unless stated.

- Reset: all outputs 0 during reset. After release, `segments`=7'h3F within 1 cycle. First `update` pulse arrives exactly 100 cycles after release.
- sig_in[0] square wave with period 10 clk, both_edges=0, ch_sel=0: second window gives `count_out`=10. Display shows tens=7'h06 (digit=1) and units=7'h3F (digit=0). `sat`=0.
- Same stimulus with both_edges=1: `count_out`=20, tens=7'h5B, units=7'h3F. Switching ch_sel to 1 (idle channel) gives `count_out`=0 one cycle later.
- sig_in[1] toggling every cycle, both_edges=1, ch_sel=1: `count_out`=100 and both digits show 7'h40. Rerun with CNT_W=4 and period 4 rising-only: 25 edges saturate, so `count_out`=15 and `sat[0]`=1.
- Single rising edge timed so it is detected in the close cycle: it is counted in the closing window (`count_out`=1). The next window gives 0.
- Assert rst_n at gate count 50 with 5 edges already counted: all outputs return to reset values. After release, the next `update` is 100 cycles later and covers only post-reset edges.
